serial_adder_ctrl: RTL and testbench

//   Bit-serial N-bit adder built around the existing FullAdder cell. It loads two

---
 rtl/serial_adder_ctrl_if.sv | 16 +
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
// The requester raises start with a, b and c_in stable; the request counts only on an edge
// where the controller is not busy. Each done pulse marks the one cycle in which sum/c_out were just updated.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two operands and a carry-in, then adds one bit pair per
// clock (LSB first) through a single FullAdder cell and reports the registered result.

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic c_in,
  output logic c_out,
  output logic S
);
  assign S     = A ^ B ^ c_in;
  assign c_out = (A & B) | (c_in & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_adder_ctrl_if.slave     bus,
  output logic [1:0]             dbg_state
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;

  logic             fa_co;
  logic             fa_s;
  logic [WIDTH-1:0] res_next;

  FullAdder u_fa (opa_q[0], opb_q[0], carry_q, fa_co, fa_s);

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at index 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        carry_d = fa_co;
        res_d   = res_next;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_next;
          c_out_d = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance checked through a result
// scoreboard plus cycle-exact busy/done checks, and a 1-bit instance for the minimum width.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  logic [1:0] dbg8;
  logic [1:0] dbg1;

  serial_adder_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(W)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8.slave),
    .dbg_state (dbg8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the 8-bit instance and queue the reference result.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit expect_result);
    logic [W:0] ref_val;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = cin;
    ref_val = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    if (expect_result) exp_q.push_back(ref_val);
    tick();
    bus8.start = 1'b0;
  endtask

  task automatic busy_then_done(input int n_busy, input string tag);
    for (int i = 0; i < n_busy; i++) begin
      check({tag, " busy"}, 32'(bus8.busy), 32'd1);
      check({tag, " done early"}, 32'(bus8.done), 32'd0);
      tick();
    end
    check({tag, " done"}, 32'(bus8.done), 32'd1);
    check({tag, " busy off"}, 32'(bus8.busy), 32'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest queued reference.
  always @(negedge clk) begin
    if (!rst && bus8.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'(bus8.done), 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sb sum", 32'(bus8.sum), 32'(e[W-1:0]));
        check("sb c_out", 32'(bus8.c_out), 32'(e[W]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst busy", 32'(bus8.busy), 32'd0);
    check("rst done", 32'(bus8.done), 32'd0);
    check("rst sum", 32'(bus8.sum), 32'h00);
    check("rst c_out", 32'(bus8.c_out), 32'd0);
    check("rst state", 32'(dbg8), 32'd0);

    // 2: basic addition with exact latency
    launch(8'h5A, 8'h33, 1'b0, 1'b1);
    busy_then_done(W, "t2");
    check("t2 sum", 32'(bus8.sum), 32'h8D);
    tick();
    check("t2 done pulse width", 32'(bus8.done), 32'd0);
    check("t2 sum hold", 32'(bus8.sum), 32'h8D);

    // 3: carry out, then a back-to-back start in the DONE cycle
    launch(8'hFF, 8'h01, 1'b0, 1'b1);
    busy_then_done(W, "t3a");
    launch(8'hFF, 8'hFF, 1'b1, 1'b1);
    check("t3 old sum held", 32'(bus8.sum), 32'h00);
    check("t3 old c_out held", 32'(bus8.c_out), 32'd1);
    busy_then_done(W, "t3b");
    check("t3b sum", 32'(bus8.sum), 32'hFF);
    tick();

    // 4: start during SHIFT is ignored
    launch(8'h0F, 8'h01, 1'b0, 1'b1);
    check("t4 busy c1", 32'(bus8.busy), 32'd1);
    tick();
    check("t4 busy c2", 32'(bus8.busy), 32'd1);
    tick();
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h01;
    bus8.c_in  = 1'b0;
    check("t4 busy c3", 32'(bus8.busy), 32'd1);
    tick();
    bus8.start = 1'b0;
    busy_then_done(W - 3, "t4");
    check("t4 sum", 32'(bus8.sum), 32'h10);
    check("t4 c_out", 32'(bus8.c_out), 32'd0);
    tick();

    // 5: reset mid-SHIFT abandons the addition
    launch(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5 busy", 32'(bus8.busy), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 busy", 32'(bus8.busy), 32'd0);
    check("t5 sum", 32'(bus8.sum), 32'h00);
    check("t5 c_out", 32'(bus8.c_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("t5 no done", 32'(bus8.done), 32'd0);
      tick();
    end

    // 6: one-bit instance
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.c_in = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("w1 busy", 32'(bus1.busy), 32'd1);
    check("w1 done early", 32'(bus1.done), 32'd0);
    tick();
    check("w1 done", 32'(bus1.done), 32'd1);
    check("w1 sum", 32'(bus1.sum), 32'd1);
    check("w1 c_out", 32'(bus1.c_out), 32'd1);
    tick();
    check("w1 done pulse width", 32'(bus1.done), 32'd0);

    tick();
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
